// File: rtl/pong_kbd_pkg.sv
// rtl/pong_kbd_pkg.sv - shared scancodes and decoder state encoding for the pong keyboard
package pong_kbd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } kbd_state_t;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BAT   = 8'hAA;
  localparam logic [7:0] SC_Q     = 8'h15;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;

  localparam int BTN_P1_UP   = 0;
  localparam int BTN_P1_DOWN = 1;
  localparam int BTN_P2_UP   = 2;
  localparam int BTN_P2_DOWN = 3;

endpackage

// File: rtl/ps2_timeout_counter.sv
// rtl/ps2_timeout_counter.sv - counts idle cycles after a prefix byte, flags the last allowed cycle
module ps2_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // Saturates at LAST; the decoder leaves the prefix state on expiry, which drops en.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr || !en) begin
      count <= '0;
    end else if (count != LAST) begin
      count <= count + CW'(1);
    end
  end

  assign expired = en && (count == LAST);

endmodule

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 scancode decoder tracking four held pong keys
module ps2_key_decoder
  import pong_kbd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  output logic [3:0] btn,
  output logic       key_press,
  output logic       err
);

  kbd_state_t state, state_next;
  logic [3:0] btn_next;
  logic       expired;

  ps2_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clr    (rx_valid),
    .en     (state != ST_IDLE),
    .expired(expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      btn       <= 4'b0000;
      key_press <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_next;
      btn       <= btn_next;
      key_press <= |(btn_next & ~btn);
      err       <= expired && !rx_valid;
    end
  end

  always_comb begin
    state_next = state;
    btn_next   = btn;
    if (rx_valid) begin
      case (state)
        ST_IDLE: begin
          case (rx_byte)
            SC_BREAK: state_next = ST_BRK;
            SC_EXT:   state_next = ST_EXT;
            SC_Q:     btn_next[BTN_P1_UP] = 1'b1;
            SC_A:     btn_next[BTN_P1_DOWN] = 1'b1;
            SC_BAT:   btn_next = 4'b0000;
            default:  state_next = ST_IDLE;
          endcase
        end
        ST_BRK: begin
          state_next = ST_IDLE;
          if (rx_byte == SC_Q) btn_next[BTN_P1_UP] = 1'b0;
          if (rx_byte == SC_A) btn_next[BTN_P1_DOWN] = 1'b0;
        end
        ST_EXT: begin
          state_next = ST_IDLE;
          if (rx_byte == SC_BREAK) state_next = ST_EXT_BRK;
          if (rx_byte == SC_UP) btn_next[BTN_P2_UP] = 1'b1;
          if (rx_byte == SC_DOWN) btn_next[BTN_P2_DOWN] = 1'b1;
        end
        ST_EXT_BRK: begin
          state_next = ST_IDLE;
          if (rx_byte == SC_UP) btn_next[BTN_P2_UP] = 1'b0;
          if (rx_byte == SC_DOWN) btn_next[BTN_P2_DOWN] = 1'b0;
        end
        default: state_next = ST_IDLE;
      endcase
    end else if (expired) begin
      // Abandon a stale prefix; held keys are left as they were.
      state_next = ST_IDLE;
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - self-checking bench for ps2_key_decoder
module tb_ps2_key_decoder;

  localparam int T = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic [3:0] btn;
  logic       key_press;
  logic       err;

  int checks = 0;
  int failures = 0;
  int kp_count = 0;
  int err_count = 0;

  logic [3:0] mdl_btn;
  logic [7:0] pfx[$];
  logic [7:0] pool[9] = '{8'hF0, 8'hE0, 8'hAA, 8'h15, 8'h1C, 8'h75, 8'h72, 8'hF0, 8'hE0};

  always #5 clk = ~clk;

  ps2_key_decoder #(.TIMEOUT_CYCLES(T)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_valid (rx_valid),
    .rx_byte  (rx_byte),
    .btn      (btn),
    .key_press(key_press),
    .err      (err)
  );

  always @(negedge clk) begin
    if (key_press) kp_count++;
    if (err) err_count++;
  end

  function automatic bit pfx_has(input logic [7:0] v);
    foreach (pfx[i]) if (pfx[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  // Reference: prefixes accumulate in a queue; the first non-prefix byte is
  // interpreted against them and the queue is emptied.
  task automatic model_byte(input logic [7:0] b);
    bit rel, ext;
    int idx;
    if (b == 8'hF0 && !pfx_has(8'hF0)) begin pfx.push_back(b); return; end
    if (b == 8'hE0 && pfx.size() == 0) begin pfx.push_back(b); return; end
    rel = pfx_has(8'hF0);
    ext = pfx_has(8'hE0);
    idx = -1;
    if (ext) begin
      if (b == 8'h75) idx = 2;
      else if (b == 8'h72) idx = 3;
    end else begin
      if (b == 8'h15) idx = 0;
      else if (b == 8'h1C) idx = 1;
    end
    if (idx >= 0) mdl_btn[idx] = !rel;
    else if (!ext && !rel && b == 8'hAA) mdl_btn = 4'b0000;
    pfx.delete();
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_byte  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_byte  = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_reset;
    #2 reset = 1'b1;
    #4 reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00;
    #3;
    checks++; if (btn !== 4'b0000 || key_press !== 1'b0 || err !== 1'b0) begin
      failures++; $display("FAIL reset_state btn=%b kp=%b err=%b exp=0000/0/0", btn, key_press, err);
    end
    #3 reset = 1'b0;
    idle(1);
  endtask

  task automatic test_make_break;
    int k0;
    pulse_reset(); k0 = kp_count;
    send(8'h15);
    checks++; if (btn !== 4'b0001 || key_press !== 1'b1) begin
      failures++; $display("FAIL q_make btn=%b kp=%b exp=0001/1", btn, key_press);
    end
    idle(1);
    checks++; if (key_press !== 1'b0) begin
      failures++; $display("FAIL q_kp_width kp=%b exp=0", key_press);
    end
    send(8'hF0);
    checks++; if (btn !== 4'b0001) begin
      failures++; $display("FAIL q_after_f0 btn=%b exp=0001", btn);
    end
    send(8'h15);
    checks++; if (btn !== 4'b0000 || key_press !== 1'b0) begin
      failures++; $display("FAIL q_break btn=%b kp=%b exp=0000/0", btn, key_press);
    end
    idle(2);
    checks++; if (kp_count - k0 != 1) begin
      failures++; $display("FAIL q_kp_count got=%0d exp=1", kp_count - k0);
    end
  endtask

  task automatic test_extended;
    int k0;
    pulse_reset(); k0 = kp_count;
    send(8'hE0); send(8'h75);
    checks++; if (btn !== 4'b0100) begin
      failures++; $display("FAIL ext_up btn=%b exp=0100", btn);
    end
    send(8'hE0); send(8'h72);
    checks++; if (btn !== 4'b1100) begin
      failures++; $display("FAIL ext_down btn=%b exp=1100", btn);
    end
    send(8'hE0); send(8'hF0); send(8'h75);
    checks++; if (btn !== 4'b1000) begin
      failures++; $display("FAIL ext_up_break btn=%b exp=1000", btn);
    end
    idle(2);
    checks++; if (kp_count - k0 != 2) begin
      failures++; $display("FAIL ext_kp_count got=%0d exp=2", kp_count - k0);
    end
  endtask

  task automatic test_typematic;
    int k0;
    pulse_reset(); k0 = kp_count;
    send(8'h1C);
    checks++; if (btn !== 4'b0010) begin
      failures++; $display("FAIL typ_first btn=%b exp=0010", btn);
    end
    send(8'h1C); send(8'h1C);
    checks++; if (btn !== 4'b0010) begin
      failures++; $display("FAIL typ_hold btn=%b exp=0010", btn);
    end
    idle(2);
    checks++; if (kp_count - k0 != 1) begin
      failures++; $display("FAIL typ_kp_count got=%0d exp=1", kp_count - k0);
    end
  endtask

  task automatic test_timeout;
    int e0, first;
    pulse_reset();
    send(8'hE0);
    e0 = err_count; first = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (err === 1'b1 && first < 0) first = k;
    end
    checks++; if (first != T) begin
      failures++; $display("FAIL timeout_cycle got=%0d exp=%0d", first, T);
    end
    checks++; if (err_count - e0 != 1) begin
      failures++; $display("FAIL timeout_err_count got=%0d exp=1", err_count - e0);
    end
    send(8'h75);
    checks++; if (btn !== 4'b0000) begin
      failures++; $display("FAIL timeout_then_75 btn=%b exp=0000", btn);
    end
    // byte arriving on the expiry cycle is decoded, no error
    send(8'hE0);
    e0 = err_count;
    idle(T - 2);
    send(8'h75);
    checks++; if (btn !== 4'b0100 || key_press !== 1'b1) begin
      failures++; $display("FAIL byte_wins btn=%b kp=%b exp=0100/1", btn, key_press);
    end
    idle(T + 4);
    checks++; if (err_count - e0 != 0) begin
      failures++; $display("FAIL byte_wins_err got=%0d exp=0", err_count - e0);
    end
  endtask

  task automatic test_bat_and_reset_mid;
    pulse_reset();
    send(8'h15); send(8'h1C);
    checks++; if (btn !== 4'b0011) begin
      failures++; $display("FAIL bat_setup btn=%b exp=0011", btn);
    end
    send(8'hAA);
    checks++; if (btn !== 4'b0000) begin
      failures++; $display("FAIL bat_clear btn=%b exp=0000", btn);
    end
    send(8'h1C);
    send(8'hF0);
    #2 reset = 1'b1;
    #1;
    checks++; if (btn !== 4'b0000) begin
      failures++; $display("FAIL async_reset btn=%b exp=0000", btn);
    end
    #2 reset = 1'b0;
    send(8'h15);
    checks++; if (btn !== 4'b0001) begin
      failures++; $display("FAIL reset_mid_seq btn=%b exp=0001", btn);
    end
  endtask

  task automatic test_random;
    logic [7:0] b;
    logic [3:0] prev;
    int r;
    pulse_reset();
    mdl_btn = 4'b0000;
    pfx.delete();
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      b = (r < 9) ? pool[r] : 8'($urandom);
      prev = mdl_btn;
      model_byte(b);
      send(b);
      checks++; if (btn !== mdl_btn || key_press !== (|(mdl_btn & ~prev))) begin
        failures++;
        $display("FAIL rand_%0d byte=%h btn=%b kp=%b exp=%b/%b", i, b, btn, key_press, mdl_btn, |(mdl_btn & ~prev));
      end
      idle($urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_extended();
    test_typematic();
    test_timeout();
    test_bat_and_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 2000000, meaning the maximum clk cycles allowed between a prefix byte and its following byte (20 ms at 100 MHz).
REQ-002 SHALL have port clk  input  1  100 MHz system clock, single clock domain.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port rx_valid  input  1  one-cycle strobe: rx_byte holds a newly received PS/2 scancode byte.
REQ-005 SHALL have port rx_byte  input  8  scancode byte from the PS/2 receiver, valid only when rx_valid=1.
REQ-006 SHALL have port btn  output  4  held-key levels: [0]=q (P1 up), [1]=a (P1 down), [2]=Up arrow (P2 up), [3]=Down arrow (P2 down).
REQ-007 SHALL have port key_press  output  1  one-cycle pulse when any btn bit rises 0->1.
REQ-008 SHALL have port err  output  1  one-cycle pulse on a prefix timeout.

Function
REQ-009 SHALL decode with a 4-state FSM: IDLE, BRK (after F0), EXT (after E0), EXT_BRK (after E0 F0).
REQ-010 SHALL sample only when rx_valid=1; rx_byte SHALL be ignored otherwise.
REQ-011 IDLE: F0->BRK; E0->EXT; 15->set btn[0]; 1C->set btn[1]; AA->clear all btn; any other byte ignored, stay IDLE.
REQ-012 BRK: 15->clear btn[0]; 1C->clear btn[1]; any other byte ignored; always return to IDLE.
REQ-013 EXT: F0->EXT_BRK; 75->set btn[2]; 72->set btn[3]; any other byte ignored, return to IDLE.
REQ-014 EXT_BRK: 75->clear btn[2]; 72->clear btn[3]; any other byte ignored; always return to IDLE.
REQ-015 btn SHALL be registered and update on the clk edge after the rx_valid cycle carrying the final byte (latency 1).
REQ-016 A repeated make code (typematic) for a key already held SHALL leave btn unchanged and SHALL NOT pulse key_press.
REQ-017 key_press SHALL assert in the same cycle that btn first shows the rising bit, for exactly one cycle.
REQ-018 A timeout counter SHALL clear on every rx_valid and count while the FSM is in BRK, EXT or EXT_BRK.
REQ-019 When the count reaches TIMEOUT_CYCLES-1 without a new byte, the FSM SHALL return to IDLE, pulse err for one cycle and leave btn unchanged.
REQ-020 If rx_valid coincides with the timeout cycle, the byte SHALL win; err SHALL NOT pulse.
REQ-021 Independent keys SHALL be tracked simultaneously; any combination of btn bits may be 1 at once.

Reset
REQ-022 Reset SHALL force state=IDLE, btn=4'b0000, key_press=0, err=0 and timeout count=0 immediately, regardless of clk.
REQ-023 Reset asserted mid-sequence (e.g. after E0) SHALL discard the partial sequence; the next byte after release SHALL be decoded from IDLE.

Structure
REQ-024 Scancode constants (F0, E0, AA, 15, 1C, 75, 72) and the FSM state encodings SHALL live in shared package pong_kbd_pkg.
REQ-025 The timeout counter SHALL be a separate sub-module, ps2_timeout_counter (inputs clr, en; output expired), sized by $clog2(TIMEOUT_CYCLES).
REQ-026 The block SHALL be combinational-loop free, and all outputs SHALL be driven directly from flops.

Verification
REQ-027 Bytes 15, then F0 15 -> btn[0] rises 1 cycle after 15 with one key_press pulse; btn[0] falls 1 cycle after the second 15; no key_press on the release.
REQ-028 Bytes E0 75, then E0 72, then E0 F0 75 -> btn=4'b0100, then 4'b1100 (two key_press pulses total), then 4'b1000.
REQ-029 Bytes 1C 1C 1C (typematic) -> btn[1]=1 after the first byte; exactly one key_press pulse.
REQ-030 Byte E0, then no byte for TIMEOUT_CYCLES (set to 16 in the bench) -> err pulses once; a following 75 sets nothing, because it is decoded from IDLE as unmapped.
REQ-031 With btn=4'b0011, byte AA -> btn=4'b0000 next cycle; separately, reset asserted after F0, then byte 15 after release -> btn[0] set (make, not break).
